// File: rtl/avalon_mem_pkg.sv
// Shared types and helpers for the Avalon burst memory agent.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_WAIT,
        RD_BURST
    } state_t;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; taps are bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [31:0] word_index(
        input logic [63:0] byte_addr,
        input int unsigned data_w,
        input int unsigned mem_words
    );
        logic [63:0] w;
        w = byte_addr >> $clog2(data_w / 8);
        return 32'(w & 64'(mem_words - 1));
    endfunction

endpackage

// File: rtl/avalon_mem_array.sv
// Single-port word RAM with per-byte write enable and registered read.
// Latency: rdata updates one clk after a cycle with re=1, otherwise holds.
// Backpressure: none; the agent never issues a read and a write in the same cycle.
module avalon_mem_array #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/avalon_burst_mem_agent.sv
// Avalon-MM burst agent fronting an on-chip word array (SDRAM stand-in); optional AVALON_AGENT_BACKPRESSURE_EN adds LFSR stalls.
// Latency: first readdatavalid READ_LAT clks after read acceptance, then len contiguous beats.
// Backpressure: waitrequest high while a read is in flight, out of reset, and on LFSR stalls when enabled.
module avalon_burst_mem_agent
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 6,
    parameter int MEM_WORDS = 4096,
    parameter int READ_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic                read,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                protocol_err
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t             state, state_n;
    logic [BURST_W-1:0] cnt, cnt_n, len, len_n;
    logic [AW-1:0]      base, base_n;
    logic               err_n;
    logic               ready;
    logic               stall;
    logic               mem_we, mem_re;
    logic [AW-1:0]      mem_addr;
    logic [AW-1:0]      cmd_idx;
    logic [BURST_W-1:0] cmd_len;
    logic               last_beat;

`ifdef AVALON_AGENT_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign cmd_idx       = AW'(word_index(64'(address), DATA_W, MEM_WORDS));
    assign cmd_len       = (burstcount == '0) ? BURST_W'(1) : burstcount;
    assign last_beat     = (cnt == len - BURST_W'(1));
    assign readdatavalid = (state == RD_BURST);
    assign waitrequest   = !ready || stall || (state == RD_WAIT) || (state == RD_BURST);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        len_n    = len;
        base_n   = base;
        err_n    = protocol_err;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = base + AW'(cnt);
        unique case (state)
            IDLE: begin
                if (!waitrequest && write) begin
                    mem_we   = 1'b1;
                    mem_addr = cmd_idx;
                    base_n   = cmd_idx;
                    len_n    = cmd_len;
                    if (read || burstcount == '0) err_n = 1'b1;
                    if (cmd_len != BURST_W'(1)) begin
                        state_n = WR_BURST;
                        cnt_n   = BURST_W'(1);
                    end
                end else if (!waitrequest && read) begin
                    base_n  = cmd_idx;
                    len_n   = cmd_len;
                    cnt_n   = '0;
                    state_n = RD_WAIT;
                    if (burstcount == '0) err_n = 1'b1;
                end
            end
            WR_BURST: begin
                if (read) err_n = 1'b1;
                if (!waitrequest && write) begin
                    mem_we = 1'b1;
                    if (last_beat) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + BURST_W'(1);
                    end
                end
            end
            RD_WAIT: begin
                // RAM read is registered, so beat 0 is fetched in the last wait cycle
                if (cnt == BURST_W'(READ_LAT - 1)) begin
                    mem_re   = 1'b1;
                    mem_addr = base;
                    state_n  = RD_BURST;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + BURST_W'(1);
                end
            end
            RD_BURST: begin
                if (last_beat) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = base + AW'(cnt + BURST_W'(1));
                    cnt_n    = cnt + BURST_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            base         <= '0;
            protocol_err <= 1'b0;
            ready        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            len          <= len_n;
            base         <= base_n;
            protocol_err <= err_n;
            ready        <= 1'b1;
        end
    end

    avalon_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (writedata),
        .be    (byteenable),
        .rdata (readdata)
    );

endmodule

// File: tb/tb_avalon_burst_mem_agent.sv
// Bench for avalon_burst_mem_agent: vector table, hand-written corner sequences, random bursts vs a word-array model.
module tb_avalon_burst_mem_agent;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_W   = 6;
    localparam int MEM_WORDS = 4096;
    localparam int READ_LAT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [5:0]  burstcount;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        protocol_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [MEM_WORDS];
    bit          known [MEM_WORDS];
    logic [31:0] wd    [32];
    logic [3:0]  wbe   [32];
    bit          wgap  [32];
    logic [31:0] got   [32];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    avalon_burst_mem_agent #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_W   (BURST_W),
        .MEM_WORDS (MEM_WORDS),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .burstcount    (burstcount),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .protocol_err  (protocol_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
        if (be == 4'hF) known[w] = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (waitrequest !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: waitrequest stuck at %b after %0d cycles", name, waitrequest, t);
        end
    endtask

    task automatic clear_gaps();
        for (int k = 0; k < 32; k++) wgap[k] = 1'b0;
    endtask

    // Starts and ends at a negedge; later beats drive junk address/burstcount.
    task automatic write_burst(input logic [31:0] addr, input int n, input logic [5:0] bc);
        int base;
        base = word_of(addr);
        for (int k = 0; k < n; k++) begin
            write      = 1'b1;
            address    = (k == 0) ? addr : 32'hBAD0_0000;
            burstcount = (k == 0) ? bc : 6'h3F;
            writedata  = wd[k];
            byteenable = wbe[k];
            wait_ready("write_accept");
            @(posedge clk);
            @(negedge clk);
            model_write((base + k) % MEM_WORDS, wd[k], wbe[k]);
            if (wgap[k]) begin
                write = 1'b0;
                @(negedge clk);
            end
        end
        write = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int n, input logic [5:0] bc, input string name);
        int  base;
        int  lat;
        bit  wr_hi;
        base  = word_of(addr);
        wr_hi = 1'b1;
        read       = 1'b1;
        address    = addr;
        burstcount = bc;
        wait_ready({name, "_accept"});
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        lat  = 0;
        while (readdatavalid !== 1'b1 && lat < 50) begin
            if (waitrequest !== 1'b1) wr_hi = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(READ_LAT));
        for (int k = 0; k < n; k++) begin
            int w;
            w = (base + k) % MEM_WORDS;
            got[k] = readdata;
            if (waitrequest !== 1'b1) wr_hi = 1'b0;
            check($sformatf("%s_valid%0d", name, k), {31'b0, readdatavalid}, 32'd1);
            if (known[w]) check($sformatf("%s_data%0d", name, k), readdata, model[w]);
            @(negedge clk);
        end
        check({name, "_end_valid"}, {31'b0, readdatavalid}, 32'd0);
        check({name, "_waitreq_busy"}, {31'b0, wr_hi}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        int          w;
        bit          saw_valid;

        rst = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
        byteenable = '0; burstcount = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        clear_gaps();

        tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'hF,    32'hFFFF_FFFF};
        tbl[2] = '{32'h0000_0020, 32'h0000_0000, 4'b0101, 32'hFF00_FF00};
        tbl[3] = '{32'h0000_0022, 32'h1234_5678, 4'b1000, 32'h1200_FF00};
        tbl[4] = '{32'h0000_0013, 32'h0000_AAAA, 4'b0011, 32'hDEAD_AAAA};
        tbl[5] = '{32'h0000_4010, 32'h5500_0000, 4'b1000, 32'h55AD_AAAA};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_waitrequest", {31'b0, waitrequest}, 32'd1);
        check("rst_rdvalid", {31'b0, readdatavalid}, 32'd0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_protocol_err", {31'b0, protocol_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_waitrequest_before_edge", {31'b0, waitrequest}, 32'd1);
        @(negedge clk);
        check("rel_waitrequest_after_edge", {31'b0, waitrequest}, 32'd0);

        // Single write / single read vectors
        for (int i = 0; i < 6; i++) begin
            wd[0]  = tbl[i].data;
            wbe[0] = tbl[i].be;
            write_burst(tbl[i].addr, 1, 6'd1);
            read_burst(tbl[i].addr, 1, 6'd1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table", i), got[0], tbl[i].exp);
        end
        check("no_err_after_vectors", {31'b0, protocol_err}, 32'd0);

        // 8-beat burst with an idle gap after beat 3
        for (int k = 0; k < 8; k++) begin
            wd[k]  = 32'(k);
            wbe[k] = 4'hF;
        end
        wgap[3] = 1'b1;
        write_burst(32'h100, 8, 6'd8);
        clear_gaps();
        read_burst(32'h100, 8, 6'd8, "burst8");
        for (int k = 0; k < 8; k++) check($sformatf("burst8_table%0d", k), got[k], 32'(k));

        // Wrap at the top of memory: words 4094, 4095, 0, 1
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int k = 0; k < 4; k++) wbe[k] = 4'hF;
        write_burst(32'h3FF8, 4, 6'd4);
        read_burst(32'h3FF8, 4, 6'd4, "wrap");
        check("wrap_order", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 32'h1122_3344);
        read_burst(32'h0, 1, 6'd1, "wrap_word0");
        check("wrap_word0_table", got[0], 32'h33);
        read_burst(32'h4, 1, 6'd1, "wrap_word1");
        check("wrap_word1_table", got[0], 32'h44);

        // Simultaneous read and write in IDLE: write wins, read dropped
        write = 1'b1; read = 1'b1; address = 32'h40; burstcount = 6'd1;
        writedata = 32'hCAFE_F00D; byteenable = 4'hF;
        wait_ready("rw_accept");
        @(posedge clk);
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        model_write(word_of(32'h40), 32'hCAFE_F00D, 4'hF);
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (readdatavalid === 1'b1) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("rw_no_rdvalid", {31'b0, saw_valid}, 32'd0);
        check("rw_protocol_err", {31'b0, protocol_err}, 32'd1);
        read_burst(32'h40, 1, 6'd1, "rw_readback");
        check("rw_readback_table", got[0], 32'hCAFE_F00D);
        check("rw_err_sticky", {31'b0, protocol_err}, 32'd1);

        // Reset in the middle of an 8-beat read burst
        for (int k = 0; k < 8; k++) begin
            wd[k]  = 32'hA0 + 32'(k);
            wbe[k] = 4'hF;
        end
        write_burst(32'h200, 8, 6'd8);
        read = 1'b1; address = 32'h200; burstcount = 6'd8;
        wait_ready("mid_accept");
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        n = 0;
        while (readdatavalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_beat0", readdata, 32'hA0);
        @(negedge clk);
        check("mid_beat1", readdata, 32'hA1);
        rst = 1'b1;
        #1;
        check("mid_rst_rdvalid", {31'b0, readdatavalid}, 32'd0);
        check("mid_rst_waitrequest", {31'b0, waitrequest}, 32'd1);
        check("mid_rst_err_cleared", {31'b0, protocol_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_waitrequest_before_edge", {31'b0, waitrequest}, 32'd1);
        @(negedge clk);
        check("mid_rel_waitrequest", {31'b0, waitrequest}, 32'd0);
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (readdatavalid === 1'b1) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("mid_no_late_beats", {31'b0, saw_valid}, 32'd0);
        read_burst(32'h200, 8, 6'd8, "mid_persist");
        read_burst(32'h10, 1, 6'd1, "mid_persist_vec");
        check("mid_persist_vec_table", got[0], 32'h55AD_AAAA);

        // burstcount=0 acts as a single beat and flags an error
        wd[0] = 32'h0BAD_C0DE; wbe[0] = 4'hF;
        write_burst(32'h44, 1, 6'd0);
        check("bc0_protocol_err", {31'b0, protocol_err}, 32'd1);
        check("bc0_back_idle", {31'b0, waitrequest}, 32'd0);
        read_burst(32'h44, 1, 6'd1, "bc0_write_read");
        check("bc0_write_table", got[0], 32'h0BAD_C0DE);
        read_burst(32'h44, 1, 6'd0, "bc0_read");

        // Random bursts against the model, via aliased byte addresses
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 8);
            w = (it % 5 == 0) ? $urandom_range(MEM_WORDS - 4, MEM_WORDS - 1)
                              : $urandom_range(0, MEM_WORDS - 1);
            for (int k = 0; k < n; k++) begin
                wd[k]   = $urandom;
                wbe[k]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                wgap[k] = ($urandom_range(0, 3) == 0);
            end
            a = 32'(w) * 4 + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 7)) << 14);
            write_burst(a, n, 6'(n));
            clear_gaps();
            a = 32'(w) * 4 + (32'($urandom_range(0, 7)) << 14);
            read_burst(a, n, 6'(n), $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avalon_burst_mem_agent.md
Name: avalon_burst_mem_agent

Overview:
Avalon-MM burst-capable agent (responder) modelling the SDRAM end of the video-controller memory path. It accepts the host-side requests the interconnect muxes onto its SDRAM port: burst writes from the stream writer and burst reads from the VGA reader. Behind the port sits an on-chip word array with configurable read latency. It serves as the synthesizable SDRAM stand-in for simulation and for FPGA bring-up without external memory.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width in bits (multiple of 8)
BURST_W, 6, burstcount width (max burst 2^(BURST_W-1) = 32)
MEM_WORDS, 4096, array depth in words (power of 2)
READ_LAT, 2, cycles from read acceptance to first readdatavalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
address  in  ADDR_W  byte address; sampled only on the first beat of a command
write  in  1  write request
writedata  in  DATA_W  write beat data
byteenable  in  DATA_W/8  per-byte write enable
burstcount  in  BURST_W  beats in the burst; sampled with the first beat
read  in  1  read request
readdata  out  DATA_W  read beat data
readdatavalid  out  1  readdata valid this cycle
waitrequest  out  1  agent stall; a request is accepted only when waitrequest=0
protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Reset: clk and rst as already decided. rst is asynchronous, active-high. On reset: waitrequest=1, readdatavalid=0, readdata=0, protocol_err=0, FSM=IDLE, counters=0. Memory contents are not cleared. waitrequest drops in the first clk after rst deasserts.
- Word index = (address >> log2(DATA_W/8)) mod MEM_WORDS. Beat k accesses (base+k) mod MEM_WORDS, so bursts wrap at the top of memory.
- burstcount=0 is treated as 1 and sets protocol_err.
- FSM states: IDLE, WR_BURST, RD_WAIT, RD_BURST.
- IDLE:
  - waitrequest=0.
  - write=1: accept beat 0 and write it with byteenable; latch base and len.
    - len=1: stay IDLE.
    - Otherwise go to WR_BURST with beat counter=1.
  - read=1 with write=0: latch base and len, go to RD_WAIT.
  - write=1 and read=1 together: write wins, the read is dropped, protocol_err=1.
- WR_BURST:
  - waitrequest=0.
  - Each cycle with write=1 accepts one beat; cycles with write=0 are idle gaps and the counter holds.
  - address and burstcount are ignored on beats after the first.
  - After the beat where counter==len-1 is accepted: return to IDLE.
  - read=1 while in WR_BURST sets protocol_err and is ignored.
- RD_WAIT:
  - waitrequest=1.
  - Counts READ_LAT-1 cycles, then goes to RD_BURST.
  - With READ_LAT=1, goes directly to RD_BURST on the next cycle.
- RD_BURST:
  - waitrequest=1.
  - readdatavalid=1 for exactly len consecutive cycles; readdata = mem[(base+k) mod MEM_WORDS].
  - After the last beat, next cycle is IDLE.
- Read latency: read accepted at edge N gives the first readdatavalid at edge N+READ_LAT.
- Only one outstanding read command; no pipelined reads.
- Array reads are registered: readdata is updated together with readdatavalid.
- readdata holds its last value when readdatavalid=0.
- Reset mid-burst: the burst is aborted immediately. Writes already accepted persist; pending read beats are never delivered.
- Counters are BURST_W bits wide; len is compared as an unsigned value.

Optional Feature:
AVALON_AGENT_BACKPRESSURE_EN
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every clk.
  - In IDLE and WR_BURST, waitrequest is additionally forced to 1 whenever lfsr[1:0]==2'b00.
  - Beats are not accepted during forced stalls.
  - RD_BURST timing is unchanged.
- Not defined: the LFSR is absent and waitrequest follows the FSM only.

Decomposition:
- Package avalon_mem_pkg holds:
  - state enum typedef (IDLE, WR_BURST, RD_WAIT, RD_BURST);
  - LFSR seed and tap constants;
  - a function converting a byte address to a word index.
- One sub-module, avalon_mem_array: single-port word RAM with byte-enable write and registered read. It keeps the block inferable as block RAM.

Test Plan:
- Single write, then single read: write address=0x10, data=0xDEADBEEF, be=4'hF, burstcount=1. A later read of 0x10 with READ_LAT=2 gives readdatavalid exactly 2 cycles after acceptance, readdata=0xDEADBEEF.
- Burst write, then burst read: write 8 beats from address 0x100 with data 0..7 and a gap cycle after beat 3. Read burst 8 from 0x100 gives 8 contiguous valid beats 0..7; waitrequest=1 throughout RD_WAIT/RD_BURST.
- Byte enables: write 0xFFFFFFFF with be=4'hF, then 0x00000000 with be=4'b0101 at the same address. Read returns 0xFF00FF00.
- Wrap-around: with MEM_WORDS=4096, burst write 4 beats starting at word 4094. Words 4094, 4095, 0, 1 are written; the read burst returns them in that order.
- Protocol errors: assert read and write together in IDLE → write performed, no readdatavalid, protocol_err=1 and sticky. burstcount=0 → single beat, protocol_err=1.
- Reset mid-read: assert rst during RD_BURST after beat 2 of 8. readdatavalid=0 immediately and waitrequest=1. After release, waitrequest=0 next cycle and memory still holds the earlier data.
